// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Types and constants shared by the VGA pattern generator:
//   mode_e           - pattern select encodings driven on mode_sel
//   COLOR_BAR_TABLE  - RGB888 colours of the eight colour bars, left to right
//   RGB_WHITE/BLACK  - full-scale and zero RGB888 colours
//   packRgb()        - converts an RGB888 colour into the output pixel format
// ---------------------------------------------------------------------------
package vga_pkg;

  // Pattern select values as seen on mode_sel.
  typedef enum logic [1:0] {
    MODE_COLORBAR = 2'd0,
    MODE_GRID     = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  // Classic colour-bar order, index 0 is the leftmost bar.
  localparam logic [23:0] COLOR_BAR_TABLE [8] = '{
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

  // For a 16-bit pixel the result is RGB565 in the low 16 bits, keeping the
  // most significant bits of each component; otherwise RGB888 is passed on.
  function automatic logic [23:0] packRgb(input logic [23:0] rgb888,
                                          input int          rgbW);
    logic [23:0] result;
    if (rgbW == 16) begin
      result = {8'h00, rgb888[23:19], rgb888[15:10], rgb888[7:3]};
    end else begin
      result = rgb888;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running horizontal/vertical raster counters and the raw (unregistered)
// timing flags decoded from them.
// Ports:
//   clk_i        pixel clock, rising edge
//   rst_i        asynchronous active-high reset, counters return to 0,0
//   hc_o         horizontal position, 0..H_TOTAL-1
//   vc_o         vertical position,   0..V_TOTAL-1
//   visible_o    current position lies in the visible region
//   hSyncAct_o   current position lies inside the horizontal sync pulse
//   vSyncAct_o   current line lies inside the vertical sync pulse
//   firstPix_o   current position is 0,0 (first visible pixel of a frame)
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] hc_o,
  output logic [VW-1:0] vc_o,
  output logic          visible_o,
  output logic          hSyncAct_o,
  output logic          vSyncAct_o,
  output logic          firstPix_o
);

  // Sync windows are held as inclusive first/last positions so the last
  // value always fits in the counter width even with a zero back porch.
  localparam logic [HW-1:0] H_MAX        = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_MAX        = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;

  // Next raster position: the line counter advances only when the pixel
  // counter wraps, and both wrap together at the end of the frame.
  always_comb begin
    hc_d = hc_q + HW'(1);
    vc_d = vc_q;
    if (hc_q == H_MAX) begin
      hc_d = '0;
      if (vc_q == V_MAX) begin
        vc_d = '0;
      end else begin
        vc_d = vc_q + VW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o       = hc_q;
  assign vc_o       = vc_q;
  assign visible_o  = (hc_q < H_ACT_END) && (vc_q < V_ACT_END);
  assign hSyncAct_o = (hc_q >= H_SYNC_FIRST) && (hc_q <= H_SYNC_LAST);
  assign vSyncAct_o = (vc_q >= V_SYNC_FIRST) && (vc_q <= V_SYNC_LAST);
  assign firstPix_o = (hc_q == '0) && (vc_q == '0);

endmodule

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
// VGA test-pattern source: raster timing plus four selectable patterns
// (colour bars, 32-pixel grid, horizontal gray ramp, solid colour).
// Every output is registered one clock after the counter state it belongs to.
// Ports:
//   clk           pixel clock, rising edge
//   rst           asynchronous active-high reset
//   mode_sel      pattern select, captured at the start of each frame
//   solid_rgb     colour for the solid pattern, captured with mode_sel
//   vga_rgb_dout  pixel data (RGB565 when RGB_W=16, RGB888 when RGB_W=24)
//   h_sync        horizontal sync, asserted at level SYNC_POL
//   v_sync        vertical sync, asserted at level SYNC_POL
//   de            data enable, high for visible pixels
//   frame_start   one-clock pulse on the first visible pixel of a frame
// RGB_W is meant to be 16 or 24 only.
// ---------------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int SYNC_POL = 0,
  parameter int RGB_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel,
  input  logic [RGB_W-1:0] solid_rgb,
  output logic [RGB_W-1:0] vga_rgb_dout,
  output logic             h_sync,
  output logic             v_sync,
  output logic             de,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // A line narrower than eight pixels still gets a non-zero bar width.
  localparam int unsigned BAR_W  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int unsigned X_LAST = H_ACTIVE - 1;
  localparam int unsigned Y_LAST = V_ACTIVE - 1;
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          visible;
  logic          hSyncAct;
  logic          vSyncAct;
  logic          firstPix;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i      (clk),
    .rst_i      (rst),
    .hc_o       (hc),
    .vc_o       (vc),
    .visible_o  (visible),
    .hSyncAct_o (hSyncAct),
    .vSyncAct_o (vSyncAct),
    .firstPix_o (firstPix)
  );

  mode_e            mode_q, mode_d;
  logic [RGB_W-1:0] solid_q, solid_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             de_q, de_d;
  logic             hSync_q, hSync_d;
  logic             vSync_q, vSync_d;
  logic             frameStart_q, frameStart_d;

  int unsigned      xPix;
  int unsigned      yPix;
  int unsigned      barIdx;
  logic [7:0]       gray;
  logic             gridOn;
  logic [23:0]      pattern888;
  logic [RGB_W-1:0] pixel;

  // Frame-level settings. At position 0,0 the live inputs are used directly
  // so that the first pixel of a frame already shows the newly chosen
  // pattern; for the rest of the frame the captured copy is used.
  always_comb begin
    mode_d  = mode_q;
    solid_d = solid_q;
    if (firstPix) begin
      mode_d  = mode_e'(mode_sel);
      solid_d = solid_rgb;
    end
  end

  // Pattern generation from the current raster position.
  always_comb begin
    xPix       = 32'(hc);
    yPix       = 32'(vc);
    barIdx     = xPix / BAR_W;
    gray       = xPix[7:0];
    gridOn     = (xPix % 32'd32 == 32'd0) || (yPix % 32'd32 == 32'd0) ||
                 (xPix == X_LAST) || (yPix == Y_LAST);
    pattern888 = RGB_BLACK;
    case (mode_d)
      MODE_COLORBAR: begin
        // Leftover pixels past the eighth bar stay black.
        if (barIdx < 32'd8) begin
          pattern888 = COLOR_BAR_TABLE[barIdx[2:0]];
        end
      end
      MODE_GRID: begin
        if (gridOn) begin
          pattern888 = RGB_WHITE;
        end
      end
      MODE_GRADIENT: begin
        pattern888 = {gray, gray, gray};
      end
      default: begin
        pattern888 = RGB_BLACK;
      end
    endcase
    // The solid colour is already in output format and bypasses packing.
    if (mode_d == MODE_SOLID) begin
      pixel = solid_d;
    end else begin
      pixel = RGB_W'(packRgb(pattern888, RGB_W));
    end
  end

  // Next values of the output registers; data is forced to zero in blanking.
  always_comb begin
    de_d         = visible;
    rgb_d        = visible ? pixel : '0;
    hSync_d      = hSyncAct ? SYNC_ON : ~SYNC_ON;
    vSync_d      = vSyncAct ? SYNC_ON : ~SYNC_ON;
    frameStart_d = firstPix;
  end

  // All outputs share this one register stage so sync, de and data stay
  // aligned with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_COLORBAR;
      solid_q      <= '0;
      rgb_q        <= '0;
      de_q         <= 1'b0;
      hSync_q      <= ~SYNC_ON;
      vSync_q      <= ~SYNC_ON;
      frameStart_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga_rgb_dout = rgb_q;
  assign de           = de_q;
  assign h_sync       = hSync_q;
  assign v_sync       = vSync_q;
  assign frame_start  = frameStart_q;

endmodule
